// File: rtl/nand_logic_bist_if.sv
// Bus bundle for nand_logic_bist: functional request/response plus BIST control/status.
interface nand_logic_bist_if #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 16
);
    logic             Valid_in;
    logic [2:0]       Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Out;
    logic             Valid_out;
    logic             Op_err;
    logic             Start;
    logic             Inject;
    logic             Busy;
    logic             Done;
    logic             Pass;
    logic [ERR_W-1:0] Err_count;

    modport master (
        output Valid_in, Op, A, B, Start, Inject,
        input  Out, Valid_out, Op_err, Busy, Done, Pass, Err_count
    );

    modport slave (
        input  Valid_in, Op, A, B, Start, Inject,
        output Out, Valid_out, Op_err, Busy, Done, Pass, Err_count
    );
endinterface

// File: rtl/nand_logic_bist.sv
// Registered bitwise logic unit built from 2-input NAND cells, with an
// exhaustive self-test sequencer comparing every opcode/operand combination
// against a behavioural golden model.
module nand_logic_bist #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 16
) (
    input logic              Clk,
    input logic              Rst_n,
    nand_logic_bist_if.slave bus
);
    // Counter holds {op[2:0], a, b}; op never exceeds 4 so NVEC-1 always fits.
    localparam int CNT_W = 2 * WIDTH + 3;
    localparam int NVEC  = 5 * (1 << (2 * WIDTH));
    localparam logic [CNT_W-1:0] LAST_VEC = CNT_W'(NVEC - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q;
    logic [CNT_W-1:0] vec_cnt_q;
    logic             run;
    logic             func_fire;

    logic [2:0]       vec_op;
    logic [WIDTH-1:0] vec_a;
    logic [WIDTH-1:0] vec_b;

    logic [2:0]       dp_op;
    logic [WIDTH-1:0] dp_a;
    logic [WIDTH-1:0] dp_b;
    logic [WIDTH-1:0] dp_res;
    logic             dp_rsvd;
    logic [WIDTH-1:0] n_ab;
    logic [WIDTH-1:0] inv_a;
    logic [WIDTH-1:0] inv_b;
    logic [WIDTH-1:0] and_r;
    logic [WIDTH-1:0] or_r;
    logic [WIDTH-1:0] xor_r;

    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] gold_q;
    logic             chk_q;
    logic             mismatch;
    logic [ERR_W-1:0] err_q;
    logic [ERR_W-1:0] err_d;
    logic             pass_q;

    logic [WIDTH-1:0] out_q;
    logic             valid_out_q;
    logic             op_err_q;

    // Single 2-input NAND cell, applied bitwise across the operand width.
    function automatic logic [WIDTH-1:0] nand2(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
        return ~(x & y);
    endfunction

    // Behavioural reference used only on the self-test compare path.
    function automatic logic [WIDTH-1:0] golden(input logic [2:0]       op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (op)
            3'd0:    return a | b;
            3'd1:    return a & b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a & b);
            3'd4:    return ~a;
            default: return '0;
        endcase
    endfunction

    assign run       = (state_q == S_RUN);
    assign func_fire = bus.Valid_in && (state_q == S_IDLE);

    assign vec_b  = vec_cnt_q[WIDTH-1:0];
    assign vec_a  = vec_cnt_q[2*WIDTH-1:WIDTH];
    assign vec_op = vec_cnt_q[CNT_W-1 -: 3];

    // The datapath is shared: self-test vectors drive it only while RUN,
    // so a request in the same cycle as Start still sees its own operands.
    assign dp_op = run ? vec_op : bus.Op;
    assign dp_a  = run ? vec_a  : bus.A;
    assign dp_b  = run ? vec_b  : bus.B;

    // NAND-only gate network and opcode select.
    always_comb begin
        n_ab   = nand2(dp_a, dp_b);
        inv_a  = nand2(dp_a, dp_a);
        inv_b  = nand2(dp_b, dp_b);
        and_r  = nand2(n_ab, n_ab);
        or_r   = nand2(inv_a, inv_b);
        xor_r  = nand2(nand2(dp_a, n_ab), nand2(dp_b, n_ab));
        dp_res = '0;
        case (dp_op)
            3'd0:    dp_res = or_r;
            3'd1:    dp_res = and_r;
            3'd2:    dp_res = xor_r;
            3'd3:    dp_res = n_ab;
            3'd4:    dp_res = inv_a;
            default: dp_res = '0;
        endcase
        dp_rsvd = (dp_op > 3'd4);
    end

    // Self-test sequencer and vector counter.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= S_IDLE;
            vec_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.Start) begin
                        state_q   <= S_RUN;
                        vec_cnt_q <= '0;
                    end
                end
                S_RUN: begin
                    if (vec_cnt_q == LAST_VEC) begin
                        state_q <= S_FLUSH;
                    end else begin
                        vec_cnt_q <= vec_cnt_q + 1'b1;
                    end
                end
                S_FLUSH: state_q <= S_DONE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Register each self-test result (with optional bit-0 fault) and its golden value.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            res_q  <= '0;
            gold_q <= '0;
            chk_q  <= 1'b0;
        end else begin
            chk_q <= run;
            if (run) begin
                res_q  <= dp_res ^ WIDTH'(bus.Inject);
                gold_q <= golden(vec_op, vec_a, vec_b);
            end
        end
    end

    // Next error count: saturating increment on a registered mismatch.
    always_comb begin
        mismatch = chk_q && (res_q != gold_q);
        err_d    = err_q;
        if (mismatch && (err_q != '1)) begin
            err_d = err_q + 1'b1;
        end
    end

    // Error counter and pass flag; pass is resolved after the final vector's check.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            err_q  <= '0;
            pass_q <= 1'b0;
        end else begin
            if ((state_q == S_IDLE) && bus.Start) begin
                err_q <= '0;
            end else begin
                err_q <= err_d;
            end
            if (state_q == S_FLUSH) begin
                pass_q <= (err_d == '0);
            end
        end
    end

    // Functional result register; requests are only accepted while idle.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            out_q       <= '0;
            valid_out_q <= 1'b0;
            op_err_q    <= 1'b0;
        end else begin
            valid_out_q <= func_fire;
            if (func_fire) begin
                out_q    <= dp_res;
                op_err_q <= dp_rsvd;
            end
        end
    end

    assign bus.Out       = out_q;
    assign bus.Valid_out = valid_out_q;
    assign bus.Op_err    = op_err_q;
    assign bus.Busy      = (state_q != S_IDLE);
    assign bus.Done      = (state_q == S_DONE);
    assign bus.Pass      = pass_q;
    assign bus.Err_count = err_q;
endmodule
